// File: rtl/repeat_mask_row_generator_pkg.sv
// Shared types and constants for the repeat mask row generator.
// Contents:
//   mask_type_e  - mask generator flavours (only REPEAT is built here)
//   mg_state_e   - row generator FSM states
//   PATTERN_BITS, SENSOR_DIM_W, PERIOD_W - shared widths
//   mod_reduce() - modulo by subtraction, used for the phase update
package repeat_mask_row_generator_pkg;

  localparam int unsigned PATTERN_BITS = 32;
  localparam int unsigned SENSOR_DIM_W = 11;
  localparam int unsigned PERIOD_W     = 5;

  typedef enum logic [1:0] {
    REPEAT = 2'b00,
    SLIDE  = 2'b01,
    RANDOM = 2'b10
  } mask_type_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } mg_state_e;

  // sum mod p for sum < 128 and p >= 1. Restoring subtraction of p<<k for k = 6..0;
  // no divider is inferred.
  function automatic logic [PERIOD_W-1:0] mod_reduce(input logic [6:0] sum,
                                                     input logic [PERIOD_W-1:0] p);
    logic [11:0] s;
    logic [11:0] sub;
    s = {5'b0, sum};
    for (int k = 6; k >= 0; k--) begin
      sub = {7'b0, p} << k;
      if (s >= sub) s = s - sub;
    end
    return PERIOD_W'(s);
  endfunction

endpackage

// File: rtl/repeat_mask_row_generator_if.sv
// Scheduler-side load bus plus downstream mask stream for the row generator.
// Modports:
//   master - drives the pattern load and mask_ready; observes the mask stream and status
//   slave  - the row generator itself
interface repeat_mask_row_generator_if #(
  parameter int unsigned OUT_W = 8
);
  import repeat_mask_row_generator_pkg::*;

  logic [SENSOR_DIM_W-1:0] image_sensor_w;
  logic [SENSOR_DIM_W-1:0] image_sensor_h;
  logic [PERIOD_W-1:0]     pattern_w;
  logic                    load_pattern;
  logic [0:PATTERN_BITS-1] pattern;
  logic                    mask_ready;
  logic [OUT_W-1:0]        mask_data;
  logic                    mask_valid;
  logic                    mask_last;
  logic                    mask_frame_last;
  logic                    rp_valid;
  logic                    busy;
  logic                    load_overrun;

  modport master (
    output image_sensor_w, image_sensor_h, pattern_w, load_pattern, pattern, mask_ready,
    input  mask_data, mask_valid, mask_last, mask_frame_last, rp_valid, busy, load_overrun
  );

  modport slave (
    input  image_sensor_w, image_sensor_h, pattern_w, load_pattern, pattern, mask_ready,
    output mask_data, mask_valid, mask_last, mask_frame_last, rp_valid, busy, load_overrun
  );

endinterface

// File: rtl/repeat_mask_row_generator_tiler.sv
// Combinational tiler: produces one OUT_W-bit beat of a row made by repeating a pattern.
// Ports:
//   pattern  - row pattern, bit 0 = first column of the period
//   period   - repeat period P (1..31)
//   phase    - pattern index of the beat's first column (< period)
//   col_base - absolute column of beat bit 0
//   width    - row width; columns at or beyond it are padded with 0
//   beat     - beat[j] = pattern[(phase + j) mod P] for column col_base + j
module repeat_mask_row_generator_tiler
  import repeat_mask_row_generator_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic [0:PATTERN_BITS-1] pattern,
  input  logic [PERIOD_W-1:0]     period,
  input  logic [PERIOD_W-1:0]     phase,
  input  logic [SENSOR_DIM_W-1:0] col_base,
  input  logic [SENSOR_DIM_W-1:0] width,
  output logic [OUT_W-1:0]        beat
);

  always_comb begin
    logic [PERIOD_W-1:0]   idx;
    logic [SENSOR_DIM_W:0] col;
    beat = '0;
    idx  = phase;
    col  = '0;
    for (int j = 0; j < OUT_W; j++) begin
      col = {1'b0, col_base} + (SENSOR_DIM_W + 1)'(j);
      if (col < {1'b0, width}) beat[j] = pattern[idx];
      // Walk the pattern index with a wrap instead of a per-bit modulo.
      idx = (idx == period - 1'b1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/repeat_mask_row_generator.sv
// Mask-generator stage: captures a 1D row pattern on load_pattern, tiles it across the
// sensor width and streams the row as OUT_W-bit beats with valid/ready. rp_valid pulses
// when the row is finished so the scheduler can supply the next pattern.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset (takes effect regardless of clk_en)
//   clk_en  - 0 freezes all state and therefore all outputs
//   bus     - slave side of repeat_mask_row_generator_if (load bus + mask stream + status)
module repeat_mask_row_generator
  import repeat_mask_row_generator_pkg::*;
#(
  parameter int unsigned max_image_sensor_w = 50,
  parameter int unsigned max_image_sensor_h = 50,
  parameter int unsigned OUT_W              = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  input logic                        clk_en,
  repeat_mask_row_generator_if.slave bus
);

  localparam logic [SENSOR_DIM_W-1:0] MaxW = SENSOR_DIM_W'(max_image_sensor_w);
  localparam logic [SENSOR_DIM_W-1:0] MaxH = SENSOR_DIM_W'(max_image_sensor_h);

  mg_state_e               state_q, state_d;
  logic [0:PATTERN_BITS-1] pat_q, pat_d;
  logic [SENSOR_DIM_W-1:0] w_q, w_d;
  logic [SENSOR_DIM_W-1:0] h_q, h_d;
  logic [PERIOD_W-1:0]     p_q, p_d;
  logic [PERIOD_W-1:0]     phase_q, phase_d;
  logic [SENSOR_DIM_W-1:0] col_q, col_d;     // beat * OUT_W
  logic [SENSOR_DIM_W-1:0] row_q, row_d;
  logic                    rp_valid_q, rp_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    zero_pend_q, zero_pend_d;

  logic [SENSOR_DIM_W-1:0] w_clamp;
  logic [SENSOR_DIM_W-1:0] h_clamp;
  logic                    emitting;
  logic                    last_beat;
  logic                    handshake;
  logic                    row_done;
  logic [OUT_W-1:0]        tile_beat;

  // Load-time clamping: W to the sensor maximum, H to 1..max, P to at least 1.
  assign w_clamp = (bus.image_sensor_w > MaxW) ? MaxW : bus.image_sensor_w;
  always_comb begin
    h_clamp = bus.image_sensor_h;
    if (h_clamp == '0) h_clamp = SENSOR_DIM_W'(1);
    else if (h_clamp > MaxH) h_clamp = MaxH;
  end

  assign emitting  = (state_q == EMIT);
  assign last_beat = emitting &&
                     ((SENSOR_DIM_W + 1)'(col_q) + (SENSOR_DIM_W + 1)'(OUT_W)
                      >= (SENSOR_DIM_W + 1)'(w_q));
  assign handshake = emitting && bus.mask_ready;

  repeat_mask_row_generator_tiler #(
    .OUT_W(OUT_W)
  ) u_tiler (
    .pattern (pat_q),
    .period  (p_q),
    .phase   (phase_q),
    .col_base(col_q),
    .width   (w_q),
    .beat    (tile_beat)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    w_d         = w_q;
    h_d         = h_q;
    p_d         = p_q;
    phase_d     = phase_q;
    col_d       = col_q;
    row_d       = row_q;
    rp_valid_d  = 1'b0;
    overrun_d   = 1'b0;
    zero_pend_d = 1'b0;
    row_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load_pattern) begin
          pat_d   = bus.pattern;
          w_d     = w_clamp;
          h_d     = h_clamp;
          p_d     = (bus.pattern_w == '0) ? PERIOD_W'(1) : bus.pattern_w;
          phase_d = '0;
          col_d   = '0;
          if (w_clamp == '0) begin
            // Empty row: complete immediately without entering EMIT.
            rp_valid_d  = 1'b1;
            zero_pend_d = 1'b1;
            row_done    = 1'b1;
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        // Loads are ignored for the whole row, including the last-beat handshake cycle.
        overrun_d = bus.load_pattern;
        if (handshake) begin
          phase_d = mod_reduce(7'(phase_q) + 7'(OUT_W), p_q);
          col_d   = col_q + SENSOR_DIM_W'(OUT_W);
          if (last_beat) begin
            state_d    = IDLE;
            rp_valid_d = 1'b1;
            row_done   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (row_done) row_d = (row_q >= h_d - 1'b1) ? '0 : row_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      p_q         <= PERIOD_W'(1);
      phase_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rp_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      zero_pend_q <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      w_q         <= w_d;
      h_q         <= h_d;
      p_q         <= p_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rp_valid_q  <= rp_valid_d;
      overrun_q   <= overrun_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  // Outputs derive only from registers, so they hold while mask_ready or clk_en is low.
  assign bus.mask_data       = emitting ? tile_beat : '0;
  assign bus.mask_valid      = emitting;
  assign bus.mask_last       = last_beat;
  assign bus.mask_frame_last = last_beat && (row_q == h_q - 1'b1);
  assign bus.rp_valid        = rp_valid_q;
  assign bus.load_overrun    = overrun_q;
  assign bus.busy            = emitting || zero_pend_q;

endmodule

// File: tb/tb_repeat_mask_row_generator.sv
module tb_repeat_mask_row_generator;

  logic clk;
  logic rst_n;
  logic clk_en;
  int   n_vec;
  int   n_err;

  repeat_mask_row_generator_if #(.OUT_W(8)) bus ();

  repeat_mask_row_generator #(
    .max_image_sensor_w(50),
    .max_image_sensor_h(50),
    .OUT_W             (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int w, input int h, input int pw, input logic [31:0] pat);
    bus.image_sensor_w = 11'(w);
    bus.image_sensor_h = 11'(h);
    bus.pattern_w      = 5'(pw);
    bus.pattern        = pat;
    bus.load_pattern   = 1'b1;
    tick();
    bus.load_pattern   = 1'b0;
  endtask

  logic [7:0] t1_exp [7];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clk_en = 1'b1;
    bus.image_sensor_w = '0;
    bus.image_sensor_h = '0;
    bus.pattern_w      = '0;
    bus.pattern        = '0;
    bus.load_pattern   = 1'b0;
    bus.mask_ready     = 1'b0;
    t1_exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h01};

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(bus.mask_valid), 32'd0);
    chk("rst_data", 32'(bus.mask_data), 32'd0);
    chk("rst_rp_valid", 32'(bus.rp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: P=4, W=50 -> six 0x55 beats then 0x01 last
    bus.mask_ready = 1'b1;
    load(50, 50, 4, 32'hA000_0000);
    for (int b = 0; b < 7; b++) begin
      chk("t1_valid", 32'(bus.mask_valid), 32'd1);
      chk("t1_data", 32'(bus.mask_data), 32'(t1_exp[b]));
      chk("t1_last", 32'(bus.mask_last), (b == 6) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t1_rp_valid", 32'(bus.rp_valid), 32'd1);
    chk("t1_valid_done", 32'(bus.mask_valid), 32'd0);
    tick();
    chk("t1_rp_pulse", 32'(bus.rp_valid), 32'd0);

    // 2: P=3, W=16 -> 0xDB, 0xB6 last
    load(16, 50, 3, 32'hC000_0000);
    chk("t2_b0", 32'(bus.mask_data), 32'hDB);
    chk("t2_b0_last", 32'(bus.mask_last), 32'd0);
    tick();
    chk("t2_b1", 32'(bus.mask_data), 32'hB6);
    chk("t2_b1_last", 32'(bus.mask_last), 32'd1);
    tick();
    chk("t2_rp_valid", 32'(bus.rp_valid), 32'd1);

    // 3: stall 5 cycles mid-row, W=24 -> 0xDB, 0xB6, 0x6D
    load(24, 50, 3, 32'hC000_0000);
    chk("t3_b0", 32'(bus.mask_data), 32'hDB);
    tick();
    chk("t3_b1", 32'(bus.mask_data), 32'hB6);
    bus.mask_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_data", 32'(bus.mask_data), 32'hB6);
      chk("t3_stall_valid", 32'(bus.mask_valid), 32'd1);
      chk("t3_stall_last", 32'(bus.mask_last), 32'd0);
    end
    bus.mask_ready = 1'b1;
    tick();
    chk("t3_b2", 32'(bus.mask_data), 32'h6D);
    chk("t3_b2_last", 32'(bus.mask_last), 32'd1);
    tick();
    chk("t3_rp_valid", 32'(bus.rp_valid), 32'd1);

    // 4: load during EMIT is ignored and flagged, also on the last-beat handshake
    bus.mask_ready = 1'b0;
    load(16, 50, 3, 32'hC000_0000);
    bus.pattern_w = 5'd1;
    bus.pattern = 32'hFFFF_FFFF;
    bus.load_pattern = 1'b1;
    tick();
    bus.load_pattern = 1'b0;
    chk("t4_overrun", 32'(bus.load_overrun), 32'd1);
    chk("t4_data_kept", 32'(bus.mask_data), 32'hDB);
    chk("t4_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t4_overrun_pulse", 32'(bus.load_overrun), 32'd0);
    bus.mask_ready = 1'b1;
    tick();
    chk("t4_b1", 32'(bus.mask_data), 32'hB6);
    bus.load_pattern = 1'b1;
    tick();
    bus.load_pattern = 1'b0;
    chk("t4_last_overrun", 32'(bus.load_overrun), 32'd1);
    chk("t4_last_rp_valid", 32'(bus.rp_valid), 32'd1);
    chk("t4_last_ignored", 32'(bus.mask_valid), 32'd0);
    tick();

    // 5a: reset mid-row
    bus.mask_ready = 1'b0;
    load(16, 2, 3, 32'hC000_0000);
    chk("t5_pre_rst_valid", 32'(bus.mask_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_valid", 32'(bus.mask_valid), 32'd0);
    chk("t5_rst_data", 32'(bus.mask_data), 32'd0);
    chk("t5_rst_last", 32'(bus.mask_last), 32'd0);
    chk("t5_rst_rp_valid", 32'(bus.rp_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_no_rp_after_rst", 32'(bus.rp_valid), 32'd0);

    // 5b: H=2, four single-beat rows -> frame_last on rows 2 and 4
    bus.mask_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      load(8, 2, 4, 32'hA000_0000);
      chk("t5_row_data", 32'(bus.mask_data), 32'h55);
      chk("t5_row_last", 32'(bus.mask_last), 32'd1);
      chk("t5_frame_last", 32'(bus.mask_frame_last), (r % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      chk("t5_row_rp_valid", 32'(bus.rp_valid), 32'd1);
    end

    // 6a: W=0 -> no beats, rp_valid the cycle after the load, row counter advances
    load(0, 2, 4, 32'hA000_0000);
    chk("t6_w0_valid", 32'(bus.mask_valid), 32'd0);
    chk("t6_w0_rp_valid", 32'(bus.rp_valid), 32'd1);
    tick();
    chk("t6_w0_rp_pulse", 32'(bus.rp_valid), 32'd0);
    chk("t6_w0_valid2", 32'(bus.mask_valid), 32'd0);
    load(8, 2, 4, 32'hA000_0000);
    chk("t6_w0_row_inc", 32'(bus.mask_frame_last), 32'd1);
    tick();

    // 6b: clk_en toggling -> same beats, frozen in disabled cycles
    load(16, 2, 3, 32'hC000_0000);
    chk("t6_ce_b0", 32'(bus.mask_data), 32'hDB);
    clk_en = 1'b0;
    tick();
    chk("t6_ce_hold_b0", 32'(bus.mask_data), 32'hDB);
    clk_en = 1'b1;
    tick();
    chk("t6_ce_b1", 32'(bus.mask_data), 32'hB6);
    chk("t6_ce_b1_last", 32'(bus.mask_last), 32'd1);
    clk_en = 1'b0;
    tick();
    chk("t6_ce_hold_b1", 32'(bus.mask_data), 32'hB6);
    chk("t6_ce_hold_rp", 32'(bus.rp_valid), 32'd0);
    clk_en = 1'b1;
    tick();
    chk("t6_ce_rp_valid", 32'(bus.rp_valid), 32'd1);
    chk("t6_ce_done_valid", 32'(bus.mask_valid), 32'd0);
    clk_en = 1'b0;
    tick();
    chk("t6_ce_rp_frozen", 32'(bus.rp_valid), 32'd1);
    clk_en = 1'b1;
    tick();
    chk("t6_ce_rp_cleared", 32'(bus.rp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
